// File: rtl/oc8051_iram_bist_ctrl.sv
// March C- self-test sequencer for the two-port 8051 internal RAM.
// Drives the RAM write/read ports while busy and records the first mismatch.
module oc8051_iram_bist_ctrl #(
    parameter logic [7:0] LAST_ADDR = 8'h0F,
    parameter logic [7:0] BG        = 8'h55
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] rd_data,
    output logic [7:0] rd_addr,
    output logic       rd_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       wr,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [7:0] fail_addr,
    output logic [7:0] fail_data,
    output logic [7:0] fail_exp,
    output logic [7:0] err_cnt
);

    typedef enum logic [2:0] {IDLE, WINIT, RD, RWR, RONLY, CHK, DONE} state_t;

    state_t     state;
    logic [2:0] elem;
    logic [7:0] addr;
    logic [7:0] exp_data;
    logic [7:0] step_addr;
    logic       dn;
    logic       last;
    logic       mism;

    // Elements 2 and 4 read back the inverted background; the rest read BG.
    always_comb begin
        exp_data  = (elem == 3'd2 || elem == 3'd4) ? ~BG : BG;
        dn        = (elem >= 3'd3);
        last      = dn ? (addr == 8'h00) : (addr == LAST_ADDR);
        step_addr = dn ? addr - 8'd1 : addr + 8'd1;
        mism      = (rd_data != exp_data);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            elem      <= '0;
            addr      <= '0;
            rd_addr   <= '0;
            rd_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            fail_exp  <= '0;
            err_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        fail      <= 1'b0;
                        err_cnt   <= '0;
                        fail_addr <= '0;
                        fail_data <= '0;
                        fail_exp  <= '0;
                        state     <= WINIT;
                        elem      <= '0;
                        addr      <= '0;
                        busy      <= 1'b1;
                        wr        <= 1'b1;
                        wr_addr   <= '0;
                        wr_data   <= BG;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        wr      <= 1'b0;
                        rd_en   <= 1'b0;
                        rd_addr <= '0;
                        wr_addr <= '0;
                        wr_data <= '0;
                        elem    <= '0;
                        addr    <= '0;
                    end else begin
                        // rd_data belongs to the read issued in the previous cycle
                        if ((state == RWR || state == CHK) && mism) begin
                            if (err_cnt != 8'hFF)
                                err_cnt <= err_cnt + 8'd1;
                            if (!fail) begin
                                fail      <= 1'b1;
                                fail_addr <= addr;
                                fail_data <= rd_data;
                                fail_exp  <= exp_data;
                            end
                        end
                        case (state)
                            WINIT: begin
                                if (addr == LAST_ADDR) begin
                                    state   <= RD;
                                    elem    <= 3'd1;
                                    addr    <= '0;
                                    wr      <= 1'b0;
                                    wr_addr <= '0;
                                    wr_data <= '0;
                                    rd_en   <= 1'b1;
                                    rd_addr <= '0;
                                end else begin
                                    addr    <= addr + 8'd1;
                                    wr_addr <= addr + 8'd1;
                                end
                            end
                            RD: begin
                                state   <= RWR;
                                rd_en   <= 1'b0;
                                rd_addr <= '0;
                                wr      <= 1'b1;
                                wr_addr <= addr;
                                wr_data <= ~exp_data;
                            end
                            RWR: begin
                                wr      <= 1'b0;
                                wr_addr <= '0;
                                wr_data <= '0;
                                rd_en   <= 1'b1;
                                if (last) begin
                                    elem <= elem + 3'd1;
                                    if (elem == 3'd4)
                                        state <= RONLY;
                                    else
                                        state <= RD;
                                    if (elem >= 3'd2) begin
                                        addr    <= LAST_ADDR;
                                        rd_addr <= LAST_ADDR;
                                    end else begin
                                        addr    <= '0;
                                        rd_addr <= '0;
                                    end
                                end else begin
                                    state   <= RD;
                                    addr    <= step_addr;
                                    rd_addr <= step_addr;
                                end
                            end
                            RONLY: begin
                                state   <= CHK;
                                rd_en   <= 1'b0;
                                rd_addr <= '0;
                            end
                            CHK: begin
                                if (addr == 8'h00) begin
                                    state <= DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                    elem  <= '0;
                                end else begin
                                    state   <= RONLY;
                                    addr    <= addr - 8'd1;
                                    rd_addr <= addr - 8'd1;
                                    rd_en   <= 1'b1;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oc8051_iram_bist_ctrl.sv
// Directed bench for the March C- BIST controller with a behavioural two-port RAM.
module tb_oc8051_iram_bist_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic start4 = 1'b0;
    int   inject = 0;

    logic [7:0] rd_data, rd_addr, wr_addr, wr_data, fail_addr, fail_data, fail_exp, err_cnt;
    logic       rd_en, wr, busy, done, fail;
    logic [7:0] rd_data4, rd_addr4, wr_addr4, wr_data4, fail_addr4, fail_data4, fail_exp4, err_cnt4;
    logic       rd_en4, wr4, busy4, done4, fail4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_tot = 0, done_tot = 0, viol = 0;
    int busy4_tot = 0, done4_tot = 0, viol4 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    oc8051_iram_bist_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .rd_data(rd_data),
        .rd_addr(rd_addr), .rd_en(rd_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr(wr),
        .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
        .fail_data(fail_data), .fail_exp(fail_exp), .err_cnt(err_cnt)
    );

    oc8051_iram_bist_ctrl #(.LAST_ADDR(8'h03), .BG(8'h55)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(1'b0), .rd_data(rd_data4),
        .rd_addr(rd_addr4), .rd_en(rd_en4), .wr_addr(wr_addr4), .wr_data(wr_data4), .wr(wr4),
        .busy(busy4), .done(done4), .fail(fail4), .fail_addr(fail_addr4),
        .fail_data(fail_data4), .fail_exp(fail_exp4), .err_cnt(err_cnt4)
    );

    // Registered-read RAM models; inject 1 clears bit 3, inject 2 inverts, both at address 05
    logic [7:0] mem [256];
    logic [7:0] mem4 [256];
    logic [7:0] rd_q, rd_a, rd_q4;

    always @(posedge clk) begin
        if (wr) mem[wr_addr] <= wr_data;
        if (rd_en) begin
            rd_q <= mem[rd_addr];
            rd_a <= rd_addr;
        end
        if (wr4) mem4[wr_addr4] <= wr_data4;
        if (rd_en4) rd_q4 <= mem4[rd_addr4];
    end

    assign rd_data  = (rd_a == 8'h05 && inject == 1) ? (rd_q & 8'hF7) :
                      (rd_a == 8'h05 && inject == 2) ? ~rd_q : rd_q;
    assign rd_data4 = rd_q4;

    always @(negedge clk) begin
        if (busy) busy_tot++;
        if (done) done_tot++;
        if (rd_addr > 8'h0F || wr_addr > 8'h0F) viol++;
        if (busy4) busy4_tot++;
        if (done4) done4_tot++;
        if (rd_addr4 > 8'h03 || wr_addr4 > 8'h03) viol4++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic run_start(input bit sel, output int t0);
        @(negedge clk);
        if (sel) start4 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        start  = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input bit sel, input int t0, output int lat);
        int n = 0;
        while (!(sel ? done4 : done) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!(sel ? done4 : done)) check("done_timeout", 0, 1);
        lat = cyc - t0;
    endtask

    int t0, lat, b0, d0, v0;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_outputs", {busy, done, wr, rd_en, fail, rd_addr, wr_addr, wr_data, err_cnt}, 0);
        check("rst_capture", {fail_addr, fail_data, fail_exp}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: clean run
        b0 = busy_tot; d0 = done_tot; v0 = viol;
        run_start(1'b0, t0);
        wait_done(1'b0, t0, lat);
        check("t1_done_lat", lat, 176);
        repeat (3) @(negedge clk);
        check("t1_busy_len", busy_tot - b0, 176);
        check("t1_done_cnt", done_tot - d0, 1);
        check("t1_fail", fail, 0);
        check("t1_err_cnt", err_cnt, 0);
        check("t1_addr_range", viol - v0, 0);
        check("t1_idle_out", {busy, wr, rd_en, rd_addr, wr_addr, wr_data}, 0);

        // 2: stuck-at-0 on bit 3 at address 05
        inject = 1;
        run_start(1'b0, t0);
        wait_done(1'b0, t0, lat);
        repeat (2) @(negedge clk);
        check("t2_fail", fail, 1);
        check("t2_fail_addr", fail_addr, 8'h05);
        check("t2_fail_exp", fail_exp, 8'hAA);
        check("t2_fail_data", fail_data, 8'hA2);
        check("t2_err_cnt", err_cnt, 2);

        // 5: asynchronous reset at cycle 50 with an early mismatch pending
        inject = 2;
        run_start(1'b0, t0);
        repeat (49) @(negedge clk);
        check("t5_fail_before", fail, 1);
        #2 rst = 1'b1;
        #1;
        check("t5_async_out", {busy, done, wr, rd_en, fail, rd_addr, wr_addr, wr_data, err_cnt}, 0);
        check("t5_async_cap", {fail_addr, fail_data, fail_exp}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_idle_after", {busy, wr, rd_en}, 0);

        // 3: abort in E3 with a recorded E2 mismatch, then restart with start+abort together
        inject = 1;
        d0 = done_tot;
        run_start(1'b0, t0);
        repeat (90) @(negedge clk);
        check("t3_busy_pre", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t3_abort_out", {busy, wr, rd_en, done}, 0);
        repeat (5) @(negedge clk);
        check("t3_no_done", done_tot - d0, 0);
        check("t3_fail_kept", {fail, err_cnt, fail_addr}, {1'b1, 8'h01, 8'h05});
        inject = 0;
        b0 = busy_tot; d0 = done_tot;
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        t0 = cyc;
        check("t3_start_wins", busy, 1);
        check("t3_fail_cleared", {fail, err_cnt}, 0);
        wait_done(1'b0, t0, lat);
        check("t3_done_lat", lat, 176);
        repeat (3) @(negedge clk);
        check("t3_busy_len", busy_tot - b0, 176);
        check("t3_clean", {fail, err_cnt}, 0);

        // 4: second start mid-run is ignored
        d0 = done_tot;
        run_start(1'b0, t0);
        repeat (40) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, t0, lat);
        check("t4_done_lat", lat, 176);
        repeat (3) @(negedge clk);
        check("t4_done_cnt", done_tot - d0, 1);
        check("t4_idle", busy, 0);

        // 6: LAST_ADDR = 03 instance
        b0 = busy4_tot; d0 = done4_tot; v0 = viol4;
        run_start(1'b1, t0);
        wait_done(1'b1, t0, lat);
        check("t6_done_lat", lat, 44);
        repeat (3) @(negedge clk);
        check("t6_busy_len", busy4_tot - b0, 44);
        check("t6_done_cnt", done4_tot - d0, 1);
        check("t6_addr_range", viol4 - v0, 0);
        check("t6_pass", {fail4, err_cnt4}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
